fv_core_ex_queue: RTL



---
 rtl/fv_core_pkg.sv | 16 +
 rtl/fv_core_ex_queue_match.sv | 43 ++++
 rtl/fv_core_ex_queue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fv_core_pkg.sv
// Shared types and widths for the fv_core instruction tracking blocks.
package fv_core_pkg;

  localparam int FV_IF_MAX_INSTR_PER_CYCLE = 2;
  localparam int FV_IF_INSTR_W             = 32;
  localparam int FV_ADDR_W                 = 32;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic [FV_IF_INSTR_W-1:0] instr;
    logic [FV_ADDR_W-1:0]     pc;
    logic                     is_dup;
    logic                     valid;
  } ex_queue_entry_t;

endpackage

// File: rtl/fv_core_ex_queue_match.sv
// Oldest-first PC matcher over the live window [head, head+count) of the
// in-flight entry ring. Returns the full wrap-bit pointer of the first hit.
module fv_core_ex_queue_match
  import fv_core_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  ex_queue_entry_t       entries [DEPTH],
  input  logic [PTR_W-1:0]      head,
  input  logic [PTR_W-1:0]      count,
  input  logic [FV_ADDR_W-1:0]  key,
  output logic                  hit,
  output logic [PTR_W-1:0]      idx
);

  localparam int IDX_W = PTR_W - 1;

  // Walk from the head; the first live match is the oldest and wins.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] ptr;
      ptr = head + PTR_W'(i);
      if (!hit && (PTR_W'(i) < count) && entries[ptr[IDX_W-1:0]].valid &&
          (entries[ptr[IDX_W-1:0]].pc == key)) begin
        hit = 1'b1;
        idx = ptr;
      end
    end
  end

  // Only pc and valid take part in the search; fold the rest away.
  logic unused_fields;
  always_comb begin
    unused_fields = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      unused_fields = unused_fields ^ (^{entries[k].instr, entries[k].is_dup});
  end

endmodule

// File: rtl/fv_core_ex_queue.sv
// In-flight instruction tracker: records instructions issued to the DUT,
// retires them in order on commit, and on a kill locates the redirecting
// instruction by PC and trims every younger entry.
module fv_core_ex_queue
  import fv_core_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_ISSUE = FV_IF_MAX_INSTR_PER_CYCLE,
  parameter int ADDR_W    = FV_ADDR_W
) (
  input  logic                                   clk,
  input  logic                                   reset_,
  input  logic                                   stall,
  input  logic [MAX_ISSUE:1]                     issue_valid,
  input  logic [MAX_ISSUE:1][FV_IF_INSTR_W-1:0]  issue_instr,
  input  logic [MAX_ISSUE:1][ADDR_W-1:0]         issue_pc,
  input  logic [MAX_ISSUE:1]                     issue_is_dup,
  input  logic                                   retire_valid,
  input  logic [ADDR_W-1:0]                      retire_pc,
  input  logic                                   kill,
  input  logic [ADDR_W-1:0]                      kill_pc,
  output logic                                   killed_instr_found,
  output ex_queue_entry_t                        killed_instr,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   err_overflow,
  output logic                                   err_underflow,
  output logic                                   err_retire_mismatch
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  ex_queue_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] head_n, tail_n;
  logic [PTR_W-1:0] space, n_acc;
  logic             hit;
  logic [PTR_W-1:0] match_ptr;
  logic             underflow, mismatch, overflow;
  logic [MAX_ISSUE:1]            wr_en;
  logic [MAX_ISSUE:1][IDX_W-1:0] wr_idx;

  fv_core_ex_queue_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
    .entries (mem),
    .head    (head_q),
    .count   (count),
    .key     (kill_pc),
    .hit     (hit),
    .idx     (match_ptr)
  );

  // Kill lookup is visible in the same cycle; silenced while in reset.
  assign killed_instr_found = reset_ && kill && hit;
  assign killed_instr       = killed_instr_found ? mem[match_ptr[IDX_W-1:0]] : '0;

  // Next-state pointers: retire first, then kill, then issue.
  always_comb begin
    head_n    = head_q;
    tail_n    = tail_q;
    underflow = 1'b0;
    mismatch  = 1'b0;
    overflow  = 1'b0;
    wr_en     = '0;
    wr_idx    = '0;
    space     = '0;
    n_acc     = '0;
    if (retire_valid) begin
      if (head_q == tail_q) begin
        underflow = 1'b1;
      end else begin
        head_n = head_q + PTR_ONE;
        if (mem[head_q[IDX_W-1:0]].pc != retire_pc) mismatch = 1'b1;
      end
    end
    if (kill) begin
      // A head match that also retires leaves tail == next head, i.e. empty.
      tail_n = hit ? (match_ptr + PTR_ONE) : head_n;
    end else if (!stall) begin
      space = PTR_DEPTH - (tail_q - head_n);
      for (int i = 1; i <= MAX_ISSUE; i++) begin
        if (issue_valid[i]) begin
          if (n_acc < space) begin
            wr_en[i]  = 1'b1;
            wr_idx[i] = tail_q[IDX_W-1:0] + n_acc[IDX_W-1:0];
            n_acc     = n_acc + PTR_ONE;
          end else begin
            overflow = 1'b1;
          end
        end
      end
      tail_n = tail_q + n_acc;
    end
  end

  // Pointer, occupancy and sticky error registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q              <= '0;
      tail_q              <= '0;
      count               <= '0;
      empty               <= 1'b1;
      full                <= 1'b0;
      err_overflow        <= 1'b0;
      err_underflow       <= 1'b0;
      err_retire_mismatch <= 1'b0;
    end else begin
      head_q              <= head_n;
      tail_q              <= tail_n;
      count               <= tail_n - head_n;
      empty               <= (tail_n == head_n);
      full                <= (tail_n[IDX_W-1:0] == head_n[IDX_W-1:0]) &&
                             (tail_n[IDX_W] != head_n[IDX_W]);
      err_overflow        <= err_overflow | overflow;
      err_underflow       <= err_underflow | underflow;
      err_retire_mismatch <= err_retire_mismatch | mismatch;
    end
  end

  // Entry storage write for accepted issue slots.
  // NOTE: storage has no reset; only entries between head and tail are ever
  // read, and those were always written first.
  always_ff @(posedge clk) begin
    for (int i = 1; i <= MAX_ISSUE; i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i]] <= '{instr:  issue_instr[i],
                            pc:     issue_pc[i],
                            is_dup: issue_is_dup[i],
                            valid:  1'b1};
      end
    end
  end

endmodule
